branch_resolve_queue: RTL
=========================

# branch_resolve_queue

In-order tracker for predicted branches between the branch predictor and `fast_core`. The front end allocates one entry per predicted branch (PC plus predicted direction). `fast_core` reports resolutions in program order via `branch_resolved`/`branch_taken`. The queue compares each outcome against the oldest entry, drives the predictor update port, and on a mispredict pulses `recovery_trigger` (which feeds `fast_core`), flushes all younger entries and blocks allocation for a fixed recovery window.

## Interface
- `DEPTH`, 8 — entries; power of two, 2..32.
- `PC_WIDTH`, 32 — PC width.
- `RECOVER_CYCLES`, 2 — cycles allocation is blocked after a mispredict; minimum 1.
- One clock; reset is asynchronous and active-high. Ports are `clk` and `rst`.
- `clk` in 1 — clock.
- `rst` in 1 — asynchronous, active-high reset.
- `alloc_valid` in 1 — front end offers a predicted branch.
- `alloc_pc` in PC_WIDTH — branch PC.
- `alloc_pred_taken` in 1 — predicted direction.
- `alloc_ready` out 1 — entry accepted when `alloc_valid && alloc_ready`.
- `branch_resolved` in 1 — one-cycle pulse from `fast_core`; the oldest branch has resolved.
- `branch_taken` in 1 — actual direction; valid with `branch_resolved`.
- `recovery_trigger` out 1 — one-cycle mispredict pulse to `fast_core`.
- `update_valid` out 1 — predictor update strobe.
- `update_pc` out PC_WIDTH — PC of the resolved entry.
- `update_taken` out 1 — actual direction.
- `update_correct` out 1 — prediction matched the outcome.
- `occupancy` out $clog2(DEPTH)+1 — live entries.
- `mispredict_count` out 16 — saturating counter.
- `resolved_count` out 16 — saturating counter.
- `orphan_err` out 1 — sticky: a resolution arrived with no matching entry.

## Operation
- **Storage:** circular buffer with head and tail pointers and a count. Each entry holds {pc, pred_taken}.
- **FSM states:**
  - RUN (reset state).
  - RECOVER: holds a down-counter.
- **`alloc_ready`:** `state==RUN && occupancy<DEPTH`. It is a function of registered state only; there is no combinational path from `alloc_valid` or `branch_resolved`.
- **Accepted allocation:** write to the tail, advance the tail, increment the count.
- **Resolution when the queue held at least one entry at the start of the cycle:**
  - Pop the head.
  - Register `update_*` from the head entry and `branch_taken`.
  - `update_correct = (pred_taken==branch_taken)`.
  - Increment `resolved_count`.
- **Mispredict (`update_correct==0`):**
  - Pulse `recovery_trigger`.
  - Increment `mispredict_count`.
  - Clear all remaining entries: head=tail, count=0.
  - Discard any allocation accepted in the same cycle.
  - Enter RECOVER with counter = RECOVER_CYCLES.
- **RECOVER:** decrement the counter each cycle; return to RUN when it reaches 0.
  - `alloc_ready` is 0 throughout.
  - A resolution arriving in RECOVER is an orphan.
- **Orphan:** a resolution when the queue was empty at cycle start, including an empty queue with an allocation in the same cycle.
  - Set `orphan_err`.
  - No update, no pop, no counter change.
- **Simultaneous allocation and correct resolution:** both take effect; net count is unchanged.
  - When full, `alloc_ready` is 0 that cycle even though the pop frees a slot.
- **Pointers:** wrap modulo DEPTH.
- **Counters:** saturate at 16'hFFFF.

## Timing
- **Resolution latency:** `branch_resolved` sampled at edge N → `update_valid`, `update_*` and `recovery_trigger` high for exactly cycle N..N+1, low afterwards unless another resolution occurs.
- **Other outputs:** `occupancy` and the counters are registered and reflect edge N in the following cycle.
- **Recovery window:** after a mispredict at edge N, `alloc_ready`=0 for RECOVER_CYCLES cycles; it is 1 again from edge N+RECOVER_CYCLES (if not full).
- **Back-to-back:** resolutions on consecutive cycles are supported at one per cycle.
- **Reset (asynchronous, any time, including mid-recovery):**
  - Pointers and count 0, FSM RUN.
  - All outputs 0, except `alloc_ready`=1 once `rst` deasserts.
  - Entry payload storage need not be reset.

## Structure
- **Shared package** (`fast_core_pkg`):
  - Entry struct {pc, pred_taken}.
  - FSM state enum {RUN, RECOVER}.
  - Counter width constant 16.
- **Sub-module:** one natural sub-module, `bq_fifo`: a parameterised circular buffer with push, pop, flush, count, full and empty. The FSM, compare logic and counters stay in the top.

## Test plan
- **In-order correct:** reset; allocate PCs 0x2000/0x2004/0x2008 with pred 1/0/1; resolve taken 1/0/1 → three `update_valid` pulses with `update_pc` 0x2000/0x2004/0x2008 and `update_correct`=1; `recovery_trigger` never asserts; `occupancy` 3→0; `resolved_count`=3.
- **Mispredict flush:** allocate 4 entries (0x3000.., all pred 0); resolve taken=1 → `recovery_trigger` single pulse, `update_pc`=0x3000, `update_correct`=0, `occupancy`=0, `alloc_ready`=0 for 2 cycles; `mispredict_count`=1.
- **Full/wrap:** allocate 8 entries → `alloc_ready`=0, an extra `alloc_valid` is ignored; resolve 3 correct, allocate 3 more (pointer wrap) → subsequent updates emerge in allocation order.
- **Simultaneous events:** on the mispredict cycle also assert `alloc_valid` → entry discarded, `occupancy`=0. On a correct resolve plus allocation at count 2 → count stays 2.
- **Orphan:** with an empty queue, pulse `branch_resolved` → `orphan_err`=1, no `update_valid`, counters unchanged; `orphan_err` remains 1 until reset.
- **Reset mid-operation:** assert `rst` during RECOVER with counters nonzero → all outputs 0 immediately; after release `alloc_ready`=1 and `occupancy`=0.

Source files
------------

// File: rtl/fast_core_pkg.sv
// fast_core_pkg
// Shared types and constants for the branch resolve queue that sits between
// the branch predictor and fast_core.
//   bq_state_t   : tracker FSM states (RUN, RECOVER)
//   bq_entry_t   : queue entry layout {pc, pred_taken} at the default PC width
//   BQ_CNT_WIDTH : width of the saturating statistics counters
package fast_core_pkg;

    localparam int unsigned BQ_CNT_WIDTH = 16;
    localparam int unsigned BQ_PC_WIDTH  = 32;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bq_state_t;

    // Default-width entry layout; the top declares the same layout sized by
    // its own PC_WIDTH parameter.
    typedef struct packed {
        logic [BQ_PC_WIDTH-1:0] pc;
        logic                   pred_taken;
    } bq_entry_t;

endpackage

// File: rtl/bq_fifo.sv
// bq_fifo
// Parameterised circular buffer used as the in-order branch queue.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   push, push_data    : write push_data at the tail (ignored when full)
//   pop                : drop the head entry (ignored when empty)
//   flush              : discard everything (head snaps to tail); wins over push/pop
//   head_data          : oldest entry, valid when !empty
//   count, full, empty : occupancy status
module bq_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 33
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == (PW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;
    assign head_data = mem[head_ptr];

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= tail_ptr;
            count    <= '0;
        end else begin
            if (do_push) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
            if (do_pop) begin
                head_ptr <= head_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue
// In-order tracker of predicted branches. Compares each fast_core resolution
// against the oldest entry, drives the predictor update port and, on a
// mispredict, pulses recovery_trigger, flushes the queue and blocks
// allocation for RECOVER_CYCLES cycles.
// Ports:
//   clk, rst                                : clock, asynchronous active-high reset
//   alloc_valid/alloc_pc/alloc_pred_taken   : new predicted branch from the front end
//   alloc_ready                             : allocation accepted when valid && ready
//   branch_resolved/branch_taken            : in-order resolution pulse from fast_core
//   recovery_trigger                        : one-cycle mispredict pulse
//   update_valid/pc/taken/correct           : registered predictor update
//   occupancy                               : live entries
//   mispredict_count/resolved_count         : saturating statistics
//   orphan_err                              : sticky resolution-without-entry flag
module branch_resolve_queue
    import fast_core_pkg::*;
#(
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned PC_WIDTH       = 32,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    input  logic [PC_WIDTH-1:0]     alloc_pc,
    input  logic                    alloc_pred_taken,
    output logic                    alloc_ready,
    input  logic                    branch_resolved,
    input  logic                    branch_taken,
    output logic                    recovery_trigger,
    output logic                    update_valid,
    output logic [PC_WIDTH-1:0]     update_pc,
    output logic                    update_taken,
    output logic                    update_correct,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic [BQ_CNT_WIDTH-1:0] mispredict_count,
    output logic [BQ_CNT_WIDTH-1:0] resolved_count,
    output logic                    orphan_err
);

    localparam int unsigned RCW = $clog2(RECOVER_CYCLES + 1);

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic                pred_taken;
    } entry_t;

    bq_state_t        state;
    logic [RCW-1:0]   recover_cnt;
    entry_t           push_entry;
    entry_t           head_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic             resolve_hit;
    logic             orphan_evt;
    logic             mispredict;
    logic             push;

    assign push_entry = '{pc: alloc_pc, pred_taken: alloc_pred_taken};

    // alloc_ready depends only on registered state (plus reset so it reads 0
    // while rst is held). During RECOVER the queue is always empty, so a
    // resolution there has no entry to match and is treated as an orphan.
    assign alloc_ready = !rst && (state == RUN) && !fifo_full;
    assign resolve_hit = branch_resolved && (state == RUN) && !fifo_empty;
    assign orphan_evt  = branch_resolved && !resolve_hit;
    assign mispredict  = resolve_hit && (head_entry.pred_taken != branch_taken);
    // An allocation accepted on the mispredict cycle is younger than the
    // failing branch, so it is dropped together with the flush.
    assign push        = alloc_valid && alloc_ready && !mispredict;

    bq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (resolve_hit),
        .flush     (mispredict),
        .head_data (head_entry),
        .count     (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Recovery FSM: loading RECOVER_CYCLES and leaving when the counter is
    // at 1 gives exactly RECOVER_CYCLES cycles with allocation blocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            recover_cnt <= '0;
        end else if (mispredict) begin
            state       <= RECOVER;
            recover_cnt <= RCW'(RECOVER_CYCLES);
        end else if (state == RECOVER) begin
            if (recover_cnt <= RCW'(1)) begin
                state       <= RUN;
                recover_cnt <= '0;
            end else begin
                recover_cnt <= recover_cnt - 1'b1;
            end
        end
    end

    // Update port and mispredict pulse are single-cycle registered strobes;
    // payload fields are zeroed when no resolution happened.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_valid     <= 1'b0;
            update_pc        <= '0;
            update_taken     <= 1'b0;
            update_correct   <= 1'b0;
            recovery_trigger <= 1'b0;
        end else begin
            update_valid     <= resolve_hit;
            update_pc        <= resolve_hit ? head_entry.pc : '0;
            update_taken     <= resolve_hit && branch_taken;
            update_correct   <= resolve_hit && !mispredict;
            recovery_trigger <= mispredict;
        end
    end

    // Saturating statistics and the sticky orphan flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resolved_count   <= '0;
            mispredict_count <= '0;
            orphan_err       <= 1'b0;
        end else begin
            if (resolve_hit && (resolved_count != '1)) begin
                resolved_count <= resolved_count + 1'b1;
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
            if (orphan_evt) begin
                orphan_err <= 1'b1;
            end
        end
    end

endmodule
